// File: rtl/fifo_read_drainer.sv
// rtl/fifo_read_drainer.sv - credit-limited FIFO reader feeding a small stream buffer with flush support
module fifo_read_drainer #(
    parameter int DATA_WIDTH = 12,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  flush_req,
    input  logic                  fifo_empty,
    input  logic                  fifo_valid,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  fifo_read_enable,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [15:0]           word_count,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic                  flush_done,
    output logic                  overflow_err
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] FULL = OW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_WIDTH-1:0]   mem [BUF_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [OW-1:0]           occupancy;
    logic                    pending;
    logic                    full;
    logic                    pop;
    logic                    push;
    logic [OW:0]             committed;

    assign full       = (occupancy == FULL);
    assign pop        = m_valid && m_ready;
    // A full buffer still takes a word when the head leaves in the same cycle.
    assign push       = fifo_valid && (!full || pop);
    assign m_valid    = (occupancy != '0);
    assign m_data     = mem[rd_ptr];
    assign flush_done = (state == DONE);

    // Outstanding read counts against free space until its one-cycle window passes.
    assign committed        = {1'b0, occupancy} + {{OW{1'b0}}, pending};
    assign fifo_read_enable = (state == RUN) && enable && !fifo_empty
                              && (committed < {1'b0, FULL});

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush_req)   state_nxt = STOP;
                else if (enable) state_nxt = RUN;
            end
            RUN: begin
                if (flush_req)    state_nxt = STOP;
                else if (!enable) state_nxt = IDLE;
            end
            STOP: begin
                if (!pending && (occupancy == '0)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occupancy    <= '0;
            pending      <= 1'b0;
            word_count   <= '0;
            checksum     <= '0;
            overflow_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= fifo_read_enable;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr     <= rd_ptr + PW'(1);
                word_count <= word_count + 16'd1;
                checksum   <= checksum ^ m_data;
            end
            if (push && !pop)      occupancy <= occupancy + OW'(1);
            else if (pop && !push) occupancy <= occupancy - OW'(1);
            if (fifo_valid && full && !pop) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fifo_read_data;
    end

endmodule
